pp_serial_loader: RTL and testbench

//   Upstream feeder and result capture for the serial partial-product shift_register/compressor pair.

---
 rtl/mul_pkg.sv | 33 +++
 rtl/pp_col_select.sv | 37 +++
 rtl/pp_serial_loader.sv | 104 ++++++++++
 tb/tb_pp_serial_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared sizing, FSM encodings and column-geometry helpers for the serial
// partial-product loader and its per-column selectors.
package mul_pkg;

  localparam int N    = 28;
  localparam int COLS = 2 * N - 1;
  localparam int PW   = 2 * N + 1;
  localparam int TW   = $clog2(N);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  localparam logic [TW-1:0] LAST_BEAT = TW'(N - 1);

  // Index of the lowest multiplicand bit contributing to column k.
  function automatic int col_lo(input int k);
    if (k > N - 1) begin
      return k - N + 1;
    end else begin
      return 0;
    end
  endfunction

  // Number of partial-product bits (column height) in column k.
  function automatic int col_h(input int k);
    if (k + 1 < 2 * N - 1 - k) begin
      return k + 1;
    end else begin
      return 2 * N - 1 - k;
    end
  endfunction

endpackage

// File: rtl/pp_col_select.sv
// Selects the single partial-product bit fed into column K on the beat
// whose column entry index is j; columns shorter than j+1 receive 0.
module pp_col_select
  import mul_pkg::*;
#(
  parameter int K = 0
) (
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [TW-1:0] j,
  output logic          src
);

  localparam int LO = col_lo(K);
  localparam int H  = col_h(K);

  localparam logic [TW:0] LO_W = (TW + 1)'(LO);
  localparam logic [TW:0] KL_W = (TW + 1)'(K - LO);
  localparam logic [TW:0] H_W  = (TW + 1)'(H);

  logic [TW:0] ia_s;
  logic [TW:0] ib_s;

  assign ia_s = LO_W + {1'b0, j};
  assign ib_s = KL_W - {1'b0, j};

  // Entries with j >= H fall outside this column; the index math is only valid below H.
  always_comb begin
    src = 1'b0;
    if ({1'b0, j} < H_W) begin
      src = a[ia_s[TW-1:0]] & b[ib_s[TW-1:0]];
    end else begin
      src = 1'b0;
    end
  end

endmodule

// File: rtl/pp_serial_loader.sv
// Operand loader for the serial partial-product array: streams one bit per
// column per beat for N beats, then captures the compressor result.
module pp_serial_loader
  import mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  output logic [COLS-1:0] src_bits,
  input  logic [PW-1:0]   dst_bus,
  output logic            busy,
  output logic            prod_valid,
  output logic [PW-1:0]   product
);

  logic [0:0]      state_r;
  logic [TW-1:0]   t_r;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic            cap_pend_r;
  logic            prod_valid_r;
  logic [PW-1:0]   product_r;

  logic            loading_s;
  logic            last_beat_s;
  logic [TW-1:0]   j_s;
  logic [COLS-1:0] col_bits_s;

  assign loading_s   = (state_r == ST_LOAD);
  assign last_beat_s = loading_s && (t_r == LAST_BEAT);
  assign j_s         = LAST_BEAT - t_r;

  assign in_ready   = (state_r == ST_IDLE) || last_beat_s;
  assign busy       = loading_s;
  assign src_bits   = loading_s ? col_bits_s : {COLS{1'b0}};
  assign prod_valid = prod_valid_r;
  assign product    = product_r;

  for (genvar k = 0; k < COLS; k++) begin : g_col
    pp_col_select #(.K(k)) u_sel (
      .a   (a_r),
      .b   (b_r),
      .j   (j_s),
      .src (col_bits_s[k])
    );
  end

  // Load FSM, beat counter and operand latch; the last beat doubles as an accept slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      t_r     <= {TW{1'b0}};
      a_r     <= {N{1'b0}};
      b_r     <= {N{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            state_r <= ST_LOAD;
            t_r     <= {TW{1'b0}};
            a_r     <= in_a;
            b_r     <= in_b;
          end
        end
        ST_LOAD: begin
          if (t_r == LAST_BEAT) begin
            t_r <= {TW{1'b0}};
            if (in_valid) begin
              a_r <= in_a;
              b_r <= in_b;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            t_r <= t_r + TW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          t_r     <= {TW{1'b0}};
        end
      endcase
    end
  end

  // Capture: the compressor holds the complete array only in the cycle after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_pend_r   <= 1'b0;
      prod_valid_r <= 1'b0;
      product_r    <= {PW{1'b0}};
    end else begin
      cap_pend_r   <= last_beat_s;
      prod_valid_r <= cap_pend_r;
      if (cap_pend_r) begin
        product_r <= dst_bus;
      end
    end
  end

endmodule

// File: tb/tb_pp_serial_loader.sv
// Directed bench for pp_serial_loader with a behavioural shift-register and
// compressor model downstream and a product scoreboard.
module tb_pp_serial_loader;
  import mul_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_a;
  logic [N-1:0]    in_b;
  logic [COLS-1:0] src_bits;
  logic [PW-1:0]   dst_bus;
  logic            busy;
  logic            prod_valid;
  logic [PW-1:0]   product;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [PW-1:0] exp_q[$];
  int pv_cycles[$];
  logic prev_pv = 1'b0;

  logic [N-1:0] sr [COLS];

  pp_serial_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .src_bits   (src_bits),
    .dst_bus    (dst_bus),
    .busy       (busy),
    .prod_valid (prod_valid),
    .product    (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int k = 0; k < COLS; k++) sr[k] = '0;
  end

  // Downstream shift registers: unreset, newest bit enters at position 0.
  always @(posedge clk) begin
    for (int k = 0; k < COLS; k++) sr[k] <= {sr[k][N-2:0], src_bits[k]};
  end

  // Compressor model: weighted population count of the newest h(k) bits per column.
  always_comb begin
    dst_bus = '0;
    for (int k = 0; k < COLS; k++) begin
      for (int i = 0; i < col_h(k); i++) begin
        if (sr[k][i] === 1'b1) dst_bus = dst_bus + (PW'(1) << k);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected product.
  always @(negedge clk) begin
    if (prod_valid === 1'b1) begin
      check("pv_not_back_to_back", 64'(prev_pv), 64'd0);
      pv_cycles.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_prod_valid", 64'd1, 64'd0);
      end else begin
        check("product", 64'(product), 64'(exp_q.pop_front()));
      end
    end
    prev_pv = (prod_valid === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input logic [N-1:0] a, input logic [N-1:0] b);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    exp_q.push_back(PW'(a) * PW'(b));
    tick();
    in_valid = 1'b0;
  endtask

  // mode 0: all-zero columns, 1: only col 0 on last beat, 2: all-ones pattern, 3: no per-beat src checks.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int mode);
    accept_op(a, b);
    for (int t = 0; t < N; t++) begin
      check("busy_beat", 64'(busy), 64'd1);
      check("ready_beat", 64'(in_ready), (t == N - 1) ? 64'd1 : 64'd0);
      case (mode)
        0: check("src_zero", 64'(src_bits), 64'd0);
        1: check("src_one", 64'(src_bits), (t == N - 1) ? 64'd1 : 64'd0);
        2: begin
          check("src27_ones", 64'(src_bits[27]), 64'd1);
          check("src54_ones", 64'(src_bits[54]), (t == N - 1) ? 64'd1 : 64'd0);
        end
        default: ;
      endcase
      tick();
    end
    check("pv_early", 64'(prod_valid), 64'd0);
    tick();
    check("pv_latency", 64'(prod_valid), 64'd1);
    tick();
    check("pv_single", 64'(prod_valid), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pv", 64'(prod_valid), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_src", 64'(src_bits), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op(28'h0, 28'h0, 0);
    run_op(28'h1, 28'h1, 1);
    run_op(28'hFFFFFFF, 28'hFFFFFFF, 2);
    check("ones_product", 64'(product), 64'h0FFFFFFE0000001);

    // Back-to-back with in_valid held; operands change while in_ready is low.
    pv_cycles.delete();
    check("b2b_idle_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_a = 28'd2;
    in_b = 28'd3;
    exp_q.push_back(PW'(6));
    tick();
    in_a = 28'd5;
    in_b = 28'd7;
    repeat (N - 1) tick();
    check("b2b_ready_last", 64'(in_ready), 64'd1);
    exp_q.push_back(PW'(35));
    tick();
    in_valid = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_not_ready", 64'(in_ready), 64'd0);
    repeat (N + 3) tick();
    check("b2b_pulses", 64'(pv_cycles.size()), 64'd2);
    if (pv_cycles.size() == 2) check("b2b_spacing", 64'(pv_cycles[1] - pv_cycles[0]), 64'd28);

    // Reset mid-load aborts the operation.
    accept_op(28'd9, 28'd9);
    repeat (10) tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_pv", 64'(prod_valid), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    check("abort_ready", 64'(in_ready), 64'd1);
    repeat (40) tick();
    check("abort_ready_after", 64'(in_ready), 64'd1);
    run_op(28'd12, 28'd13, 3);

    // Idle with in_valid low.
    for (int i = 0; i < 50; i++) begin
      check("idle_state", 64'({busy, in_ready, prod_valid}), 64'b010);
      check("idle_src", 64'(src_bits), 64'd0);
      tick();
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
